// File: rtl/sfr_bus_arbiter_if.sv
// Two-master SFR access bus plus the SFR-block and serial-transmitter side signals.
// slave = arbiter view, master = requester/environment view.
interface sfr_bus_arbiter_if;
  logic       m0_req,   m1_req;
  logic       m0_we,    m1_we;
  logic [7:0] m0_addr,  m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt,   m1_gnt;
  logic       m0_err,   m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_write_val;
  logic       sfr_write_valid;
  logic [7:0] sfr_read_val;
  logic       tx_busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  sfr_read_val, tx_busy,
    output m0_gnt, m1_gnt, m0_err, m1_err, m0_rdata, m1_rdata,
    output sfr_addr, sfr_write_val, sfr_write_valid
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output sfr_read_val, tx_busy,
    input  m0_gnt, m1_gnt, m0_err, m1_err, m0_rdata, m1_rdata,
    input  sfr_addr, sfr_write_val, sfr_write_valid
  );
endinterface

// File: rtl/sfr_bus_arbiter.sv
// Round-robin arbiter between CPU (m0) and debug master (m1) onto a single SFR port,
// with flow control and timeout abort for writes into the serial transmitter range.
module sfr_bus_arbiter #(
  parameter logic [7:0]  SOUT_ADDR     = 8'd9,
  parameter logic [15:0] SOUT_WAIT_MAX = 16'd65535
) (
  input logic              clk,
  input logic              nrst,
  sfr_bus_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, SAMPLE, WAIT_TX} state_e;

  state_e          state_q;
  logic [1:0]      req;
  logic [1:0]      gnt_q, err_q;
  logic [1:0][7:0] rdata_q;
  logic            last_q, win_q, win_d, we_q, wr_vld_q;
  logic [7:0]      addr_q, wdata_q;
  logic [15:0]     cnt_q;
  logic            wait_done;

  assign req = {bus.m1_req, bus.m0_req};

  // On contention the port that was not served last wins.
  always_comb begin
    win_d = req[1];
    if (&req) win_d = ~last_q;
  end

  // Current WAIT_TX cycle is the SOUT_WAIT_MAX-th consecutive one.
  assign wait_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, SOUT_WAIT_MAX};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_vld_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      gnt_q    <= '0;
      err_q    <= '0;
      wr_vld_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          win_q   <= win_d;
          we_q    <= win_d ? bus.m1_we    : bus.m0_we;
          addr_q  <= win_d ? bus.m1_addr  : bus.m0_addr;
          wdata_q <= win_d ? bus.m1_wdata : bus.m0_wdata;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
        SETUP: begin
          if (!we_q) begin
            rdata_q[win_q] <= bus.sfr_read_val;
            gnt_q[win_q]   <= 1'b1;
            last_q         <= win_q;
            state_q        <= SAMPLE;
          end else if (addr_q >= SOUT_ADDR && bus.tx_busy) begin
            state_q <= WAIT_TX;
          end else begin
            wr_vld_q <= 1'b1;
            state_q  <= STROBE;
          end
        end
        WAIT_TX: begin
          if (!bus.tx_busy) begin
            wr_vld_q <= 1'b1;
            state_q  <= STROBE;
          end else begin
            if (cnt_q != SOUT_WAIT_MAX) cnt_q <= cnt_q + 16'd1;
            // Timed out: complete with error, the write never reaches the SFR block.
            if (wait_done) begin
              gnt_q[win_q] <= 1'b1;
              err_q[win_q] <= 1'b1;
              last_q       <= win_q;
              state_q      <= RELEASE;
            end
          end
        end
        STROBE: begin
          gnt_q[win_q] <= 1'b1;
          last_q       <= win_q;
          state_q      <= RELEASE;
        end
        RELEASE, SAMPLE: state_q <= IDLE;
        default:         state_q <= IDLE;
      endcase
    end
  end

  assign bus.sfr_addr        = (state_q == IDLE) ? 8'd0 : addr_q;
  assign bus.sfr_write_val   = (state_q == IDLE) ? 8'd0 : wdata_q;
  assign bus.sfr_write_valid = wr_vld_q;
  assign bus.m0_gnt          = gnt_q[0];
  assign bus.m1_gnt          = gnt_q[1];
  assign bus.m0_err          = err_q[0];
  assign bus.m1_err          = err_q[1];
  assign bus.m0_rdata        = rdata_q[0];
  assign bus.m1_rdata        = rdata_q[1];
endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected gnt/strobe events, a negedge monitor pops and compares.
module tb_sfr_bus_arbiter;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sfr_bus_arbiter_if bus ();
  sfr_bus_arbiter_if bus4 ();

  sfr_bus_arbiter dut (.clk(clk), .nrst(nrst), .bus(bus));
  sfr_bus_arbiter #(.SOUT_WAIT_MAX(16'd4)) dut4 (.clk(clk), .nrst(nrst), .bus(bus4));

  typedef struct {
    int          inst;
    logic [1:0]  gv;
    logic [1:0]  ev;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    int unsigned cyc;
  } gexp_t;
  typedef struct {
    int          inst;
    logic [7:0]  a;
    logic [7:0]  d;
    int unsigned cyc;
  } sexp_t;

  gexp_t      gq[$];
  sexp_t      sq[$];
  logic [7:0] mrd [2][2];
  int         checks = 0, errors = 0, tmo = 0;
  bit         fin_req = 0, fin_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic mon(input int i, input logic [1:0] gv, input logic [1:0] ev,
                     input logic [7:0] r0, input logic [7:0] r1,
                     input logic wv, input logic [7:0] a, input logic [7:0] d);
    gexp_t g;
    sexp_t s;
    if (gv != 2'b00) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(gv), 32'd0);
      else begin
        g = gq.pop_front();
        chk("gnt_inst", i, g.inst);
        chk("gnt_vec", 32'(gv), 32'(g.gv));
        chk("err_vec", 32'(ev), 32'(g.ev));
        chk("gnt_cycle", cyc, g.cyc);
        chk("rdata_m0", 32'(r0), 32'(g.rd0));
        chk("rdata_m1", 32'(r1), 32'(g.rd1));
      end
    end else if (ev != 2'b00) chk("err_without_gnt", 32'(ev), 32'd0);
    if (wv) begin
      if (sq.size() == 0) chk("strobe_unexpected", 32'(wv), 32'd0);
      else begin
        s = sq.pop_front();
        chk("strobe_inst", i, s.inst);
        chk("strobe_addr", 32'(a), 32'(s.a));
        chk("strobe_data", 32'(d), 32'(s.d));
        chk("strobe_cycle", cyc, s.cyc);
      end
    end
  endtask

  // Monitor: the only process that counts comparisons.
  initial forever begin
    @(negedge clk);
    if (fin_req && !fin_done) begin
      chk("gnt_queue_empty", gq.size(), 0);
      chk("strobe_queue_empty", sq.size(), 0);
      chk("gnt_timeouts", tmo, 0);
      fin_done = 1;
    end else if (!nrst) begin
      chk("rst_write_valid", 32'(bus.sfr_write_valid), 32'd0);
      chk("rst_sfr_addr", 32'(bus.sfr_addr), 32'd0);
      chk("rst_write_val", 32'(bus.sfr_write_val), 32'd0);
      chk("rst_gnt", 32'({bus.m1_gnt, bus.m0_gnt, bus.m1_err, bus.m0_err}), 32'd0);
      chk("rst_rdata", 32'({bus.m1_rdata, bus.m0_rdata}), 32'd0);
      chk("rst_write_valid_4", 32'(bus4.sfr_write_valid), 32'd0);
    end else begin
      mon(0, {bus.m1_gnt, bus.m0_gnt}, {bus.m1_err, bus.m0_err}, bus.m0_rdata, bus.m1_rdata,
          bus.sfr_write_valid, bus.sfr_addr, bus.sfr_write_val);
      mon(1, {bus4.m1_gnt, bus4.m0_gnt}, {bus4.m1_err, bus4.m0_err}, bus4.m0_rdata, bus4.m1_rdata,
          bus4.sfr_write_valid, bus4.sfr_addr, bus4.sfr_write_val);
    end
  end

  task automatic drive(input int i, input bit p, input logic r, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (i == 0 && !p) begin bus.m0_req = r;  bus.m0_we = we;  bus.m0_addr = a;  bus.m0_wdata = d;  end
    if (i == 0 &&  p) begin bus.m1_req = r;  bus.m1_we = we;  bus.m1_addr = a;  bus.m1_wdata = d;  end
    if (i == 1 && !p) begin bus4.m0_req = r; bus4.m0_we = we; bus4.m0_addr = a; bus4.m0_wdata = d; end
    if (i == 1 &&  p) begin bus4.m1_req = r; bus4.m1_we = we; bus4.m1_addr = a; bus4.m1_wdata = d; end
  endtask

  function automatic logic gnt_of(input int i, input bit p);
    if (i == 0) return p ? bus.m1_gnt : bus.m0_gnt;
    return p ? bus4.m1_gnt : bus4.m0_gnt;
  endfunction

  // Called just after a rising edge with the DUT in IDLE; lat = cycles from acceptance to gnt.
  task automatic issue(input int i, input bit p, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input int lat, input bit err, input logic [7:0] rv);
    gexp_t g;
    sexp_t s;
    if (!we) begin
      mrd[i][p] = rv;
      if (i == 0) bus.sfr_read_val = rv; else bus4.sfr_read_val = rv;
    end
    drive(i, p, 1'b1, we, a, d);
    g.inst = i; g.gv = p ? 2'b10 : 2'b01; g.ev = err ? g.gv : 2'b00;
    g.rd0 = mrd[i][0]; g.rd1 = mrd[i][1]; g.cyc = cyc + lat;
    gq.push_back(g);
    if (we && !err) begin
      s.inst = i; s.a = a; s.d = d; s.cyc = cyc + lat - 1;
      sq.push_back(s);
    end
  endtask

  task automatic complete(input int i, input bit p);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = gnt_of(i, p);
    end
    if (!got) tmo++;
    @(posedge clk); #1;
    drive(i, p, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    int n;
    gexp_t g;
    for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) mrd[i][p] = 8'd0;
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    bus.tx_busy = 0;  bus.sfr_read_val = 8'h00;
    bus4.tx_busy = 0; bus4.sfr_read_val = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // Both masters request continuously from reset: m0, m1, m0, m1 (reads, 3-cycle period).
    bus.sfr_read_val = 8'h66;
    drive(0, 0, 1, 0, 8'd2, 8'd0);
    drive(0, 1, 1, 0, 8'd3, 8'd0);
    for (int k = 0; k < 4; k++) begin
      g.inst = 0; g.gv = k[0] ? 2'b10 : 2'b01; g.ev = 2'b00;
      g.rd0 = 8'h66; g.rd1 = (k == 0) ? 8'h00 : 8'h66; g.cyc = cyc + 2 + 3 * k;
      gq.push_back(g);
    end
    mrd[0][0] = 8'h66; mrd[0][1] = 8'h66;
    n = 0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) n++;
    end
    if (n < 4) tmo++;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);

    // Plain write, plain read, read hold, addresses around SOUT_ADDR.
    issue(0, 0, 1, 8'd5, 8'h3C, 3, 0, 8'h00);  complete(0, 0);
    issue(0, 1, 0, 8'd1, 8'h00, 2, 0, 8'hA7);  complete(0, 1);
    issue(0, 0, 0, 8'h20, 8'h00, 2, 0, 8'h5B); complete(0, 0);
    bus.tx_busy = 1;
    issue(0, 1, 1, 8'd8, 8'hE1, 3, 0, 8'h00);  complete(0, 1);
    bus.tx_busy = 0;
    issue(0, 1, 1, 8'd9, 8'h5A, 3, 0, 8'h00);  complete(0, 1);

    // SOUT write stalled: tx_busy high for 10 cycles, strobe the cycle after it falls.
    bus.tx_busy = 1;
    issue(0, 0, 1, 8'd9, 8'h41, 12, 0, 8'h00);
    repeat (10) @(posedge clk);
    #1 bus.tx_busy = 0;
    complete(0, 0);

    // SOUT_WAIT_MAX = 4: abort with err, then a fresh stall must not inherit the count.
    bus4.tx_busy = 1;
    issue(1, 0, 1, 8'd9, 8'h77, 6, 1, 8'h00);  complete(1, 0);
    issue(1, 1, 1, 8'd10, 8'h33, 5, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1 bus4.tx_busy = 0;
    complete(1, 1);

    // Reset while in STROBE: no gnt for the dropped write, next access normal.
    drive(0, 0, 1, 1, 8'd7, 8'h99);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b0;
    for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) mrd[i][p] = 8'd0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;
    issue(0, 1, 1, 8'd4, 8'h12, 3, 0, 8'h00);  complete(0, 1);
    issue(0, 0, 0, 8'd6, 8'h00, 2, 0, 8'hC3);  complete(0, 0);

    repeat (2) @(posedge clk);
    fin_req = 1;
    for (int k = 0; k < 5 && !fin_done; k++) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
